seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, 1000, clk cycles each digit is selected; legal range 4..65535.
REQ-002 Parameter GUARD, 2, cycles at the start of each digit slot with all anodes off (anti-ghosting); legal range 1..SCAN_DIV-2.
REQ-003 Port clk  input  1  sole clock; all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port min0  input  4  BCD minutes digit from the stopwatch.
REQ-006 Port sec1  input  4  BCD tens-of-seconds digit.
REQ-007 Port sec0  input  4  BCD seconds digit.
REQ-008 Port milSec0  input  4  BCD sub-second digit.
REQ-009 Port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-010 Port an  output  4  active-low digit anodes; an[0] rightmost.
REQ-011 Port dp  output  1  active-low decimal point.

Function
REQ-012 Prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; "tick" = cnt==SCAN_DIV-1.
REQ-013 Digit index idx SHALL advance on tick: 0->1->2->3->0.
REQ-014 Mapping SHALL be idx0=milSec0/an[0], idx1=sec0/an[1], idx2=sec1/an[2], idx3=min0/an[3].
REQ-015 Snapshot registers SHALL load all four inputs on the tick where idx==3 (frame boundary); display SHALL use only the snapshot, so a frame never mixes digits from different input values.
REQ-016 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; values 10..15 SHALL display dash 0111111.
REQ-017 dp SHALL be 0 while idx==3 or idx==1 (format M.SS.m), else 1.
REQ-018 While cnt<GUARD, an SHALL be 1111; otherwise exactly one an bit (an[idx]) SHALL be 0.
REQ-019 seg, an, dp SHALL be registered: one-cycle latency from the (cnt, idx, snapshot) state that selects them.
REQ-020 Inputs SHALL be sampled only at frame boundaries; input changes at any other time SHALL have no effect on outputs.

Reset
REQ-021 reset low SHALL immediately force cnt=0, idx=0, snapshot=0, an=1111, seg=1111111, dp=1, regardless of clk.
REQ-022 After reset release, first frame SHALL show 0000 from the zeroed snapshot; first input snapshot SHALL occur at the end of that frame.
REQ-023 Reset asserted mid-slot or mid-frame SHALL abandon the scan; scanning SHALL restart at idx0, cnt0 on release.

Configuration
REQ-024 Macro SEG_SCAN_LZB_EN: when defined, idx3 slot SHALL be blanked (seg=1111111, dp=1, an[3] still scanned) whenever snapshot min0==0; when undefined, min0 is always displayed as decoded.

Verification (SCAN_DIV=4, GUARD=1 unless stated)
REQ-025 Reset then inputs 1,2,3,4 (min0,sec1,sec0,milSec0) -> first frame all digits 1000000; second frame an[0] seg 0011001, an[1] seg 0110000 dp 0, an[2] seg 0100100, an[3] seg 1111001 dp 0.
REQ-026 Within one slot -> an=1111 for exactly 1 cycle then an[idx]=0 for 3 cycles; full frame = 16 cycles.
REQ-027 Change milSec0 5->6 mid-frame -> 5 shown until the next frame boundary, 6 on the frame after; no frame shows a mix.
REQ-028 sec1=12 -> idx2 slot shows 0111111.
REQ-029 Assert reset mid idx2 slot -> outputs go blank asynchronously; after release scan restarts at an[0] with snapshot 0.
REQ-030 With SEG_SCAN_LZB_EN, min0=0 -> idx3 slot seg=1111111, dp=1; min0=7 -> 1111000, dp=0; without macro min0=0 -> 1000000.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner for an M.SS.m stopwatch display.
// Optional macro SEG_SCAN_LZB_EN blanks the minutes digit while it is zero.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned GUARD    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] min0,
  input  logic [3:0] sec1,
  input  logic [3:0] sec0,
  input  logic [3:0] milSec0,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned     CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD values show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b0111111;
    endcase
    return p;
  endfunction

  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [1:0]       idx_r, idx_nxt_s;
  logic [15:0]      snap_r, snap_nxt_s;
  logic             tick_s;
  logic [3:0]       digit_s;
  logic             blank_s;
  logic [6:0]       seg_nxt_s;
  logic [3:0]       an_nxt_s;
  logic             dp_nxt_s;

  // Scan state register: prescaler, digit index and frame snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= '0;
      idx_r  <= 2'd0;
      snap_r <= 16'h0000;
    end else begin
      cnt_r  <= cnt_nxt_s;
      idx_r  <= idx_nxt_s;
      snap_r <= snap_nxt_s;
    end
  end

  // Next-state logic; inputs are captured only as the last slot of a frame ends.
  always_comb begin
    tick_s     = (cnt_r == CNT_MAX);
    cnt_nxt_s  = cnt_r;
    idx_nxt_s  = idx_r;
    snap_nxt_s = snap_r;
    if (tick_s) begin
      cnt_nxt_s = '0;
      idx_nxt_s = idx_r + 2'd1;
      if (idx_r == 2'd3) begin
        snap_nxt_s = {min0, sec1, sec0, milSec0};
      end else begin
        snap_nxt_s = snap_r;
      end
    end else begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Output selection from the current scan state.
  always_comb begin
    case (idx_r)
      2'd0:    digit_s = snap_r[3:0];
      2'd1:    digit_s = snap_r[7:4];
      2'd2:    digit_s = snap_r[11:8];
      2'd3:    digit_s = snap_r[15:12];
      default: digit_s = 4'd0;
    endcase
`ifdef SEG_SCAN_LZB_EN
    blank_s = (idx_r == 2'd3) && (snap_r[15:12] == 4'd0);
`else
    blank_s = 1'b0;
`endif
    if (blank_s) begin
      seg_nxt_s = 7'b1111111;
      dp_nxt_s  = 1'b1;
    end else begin
      seg_nxt_s = bcd_to_seg(digit_s);
      dp_nxt_s  = ~idx_r[0];
    end
    // Guard cycles keep every anode off so the previous digit cannot ghost.
    if (cnt_r < GUARD_C) begin
      an_nxt_s = 4'b1111;
    end else begin
      an_nxt_s = ~(4'b0001 << idx_r);
    end
  end

  // Output register: one cycle behind the selecting state, blank in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= 7'b1111111;
      an  <= 4'b1111;
      dp  <= 1'b1;
    end else begin
      seg <= seg_nxt_s;
      an  <= an_nxt_s;
      dp  <= dp_nxt_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with an elapsed-cycle display model.
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int G  = 1;
  localparam logic [6:0] SEG_TAB [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] min0 = 4'd0, sec1 = 4'd0, sec0 = 4'd0, milSec0 = 4'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  int         step;
  logic [15:0] msnap;
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_dp;

  seg_scan_driver #(.SCAN_DIV(SD), .GUARD(G)) dut (
    .clk(clk), .reset(reset), .min0(min0), .sec1(sec1), .sec0(sec0),
    .milSec0(milSec0), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_an(input int s);
    logic [3:0] one = 4'b0001;
    if ((s % SD) < G) return 4'b1111;
    return 4'b1111 ^ (one << ((s / SD) % 4));
  endfunction

  function automatic bit m_blank(input int s, input logic [15:0] sn);
`ifdef SEG_SCAN_LZB_EN
    return (((s / SD) % 4) == 3) && (sn[15:12] == 4'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [6:0] m_seg(input int s, input logic [15:0] sn);
    int d = (s / SD) % 4;
    if (m_blank(s, sn)) return 7'b1111111;
    return SEG_TAB[sn[4*d +: 4]];
  endfunction

  function automatic logic m_dp(input int s, input logic [15:0] sn);
    int d = (s / SD) % 4;
    if (m_blank(s, sn)) return 1'b1;
    return (d == 1 || d == 3) ? 1'b0 : 1'b1;
  endfunction

  // Model: outputs follow the elapsed-cycle position; snapshot taken every 4*SD cycles.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      step    <= 0;
      msnap   <= 16'h0000;
      exp_an  <= 4'b1111;
      exp_seg <= 7'b1111111;
      exp_dp  <= 1'b1;
    end else begin
      exp_an  <= m_an(step);
      exp_seg <= m_seg(step, msnap);
      exp_dp  <= m_dp(step, msnap);
      step    <= step + 1;
      if ((step % (4 * SD)) == (4 * SD - 1)) msnap <= {min0, sec1, sec0, milSec0};
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        miscompares++;
        $display("FAIL cycle step=%0d: an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                 step, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  end

  task automatic lit(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    vectors++;
    if (an !== ea || seg !== es || dp !== ed) begin
      miscompares++;
      $display("FAIL %s: an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
               name, an, seg, dp, ea, es, ed);
    end
  endtask

  // Wait until the outputs of scan state s are visible.
  task automatic wait_step(input int s);
    for (int i = 0; i < 400 && step != s + 1; i++) @(negedge clk);
    if (step != s + 1) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout waiting for step %0d: at %0d", s, step);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    lit("reset_state", 4'b1111, 7'b1111111, 1'b1);
    reset = 1'b1;
    min0 = 4'd1; sec1 = 4'd2; sec0 = 4'd3; milSec0 = 4'd4;

    wait_step(0);  lit("f0_guard",   4'b1111, 7'b1000000, 1'b1);
    wait_step(5);  lit("f0_idx1",    4'b1101, 7'b1000000, 1'b0);
    wait_step(16); lit("f1_guard",   4'b1111, 7'b0011001, 1'b1);
    wait_step(17); lit("f1_idx0",    4'b1110, 7'b0011001, 1'b1);
    wait_step(21); lit("f1_idx1",    4'b1101, 7'b0110000, 1'b0);
    wait_step(25); lit("f1_idx2",    4'b1011, 7'b0100100, 1'b1);
    wait_step(29); lit("f1_idx3",    4'b0111, 7'b1111001, 1'b0);

    wait_step(34); milSec0 = 4'd5;
    wait_step(45); lit("f2_idx3",    4'b0111, 7'b1111001, 1'b0);
    wait_step(49); lit("f3_ms5",     4'b1110, 7'b0010010, 1'b1);
    wait_step(50); milSec0 = 4'd6;
    wait_step(51); lit("f3_ms5_hold", 4'b1110, 7'b0010010, 1'b1);
    wait_step(61); lit("f3_idx3",    4'b0111, 7'b1111001, 1'b0);
    wait_step(65); lit("f4_ms6",     4'b1110, 7'b0000010, 1'b1);
    wait_step(70); sec1 = 4'd12;
    wait_step(73); lit("f4_sec1_old", 4'b1011, 7'b0100100, 1'b1);
    wait_step(89); lit("f5_dash",    4'b1011, 7'b0111111, 1'b1);

    wait_step(90);
    #2 reset = 1'b0;
    #1 lit("async_reset", 4'b1111, 7'b1111111, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_step(0);  lit("r_guard",    4'b1111, 7'b1000000, 1'b1);
    wait_step(1);  lit("r_idx0",     4'b1110, 7'b1000000, 1'b1);
    min0 = 4'd0;
    wait_step(9);  lit("r_idx2_zero", 4'b1011, 7'b1000000, 1'b1);
    wait_step(25); lit("r_f1_dash",  4'b1011, 7'b0111111, 1'b1);
`ifdef SEG_SCAN_LZB_EN
    wait_step(29); lit("lzb_blank",  4'b0111, 7'b1111111, 1'b1);
`else
    wait_step(29); lit("min0_zero",  4'b0111, 7'b1000000, 1'b0);
`endif
    wait_step(30); min0 = 4'd7;
    wait_step(45); lit("min0_seven", 4'b0111, 7'b1111000, 1'b0);
    wait_step(60);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
